// File: rtl/video_fetch_pkg.sv
// Shared video-path definitions: bandwidth descriptor encodings, byte-steering
// selects and render-mode constants common with the mode decoder.
package video_fetch_pkg;

   localparam logic [1:0] BW2 = 2'b00;
   localparam logic [1:0] BW4 = 2'b01;
   localparam logic [1:0] BW8 = 2'b11;

   localparam logic [2:0] BU1 = 3'b001;
   localparam logic [2:0] BU2 = 3'b010;
   localparam logic [2:0] BU4 = 3'b100;

   localparam logic [1:0] BSL_LO   = 2'b00;
   localparam logic [1:0] BSL_ALT  = 2'b01;
   localparam logic [1:0] BSL_WORD = 2'b10;
   localparam logic [1:0] BSL_HI   = 2'b11;

   typedef enum logic [1:0] {
      RM_TEXT  = 2'b00,
      RM_GFX4  = 2'b01,
      RM_GFX8  = 2'b10,
      RM_BLANK = 2'b11
   } render_mode_t;

   // Period code 10 has no own meaning and is folded into the 8-cycle period.
   function automatic logic [2:0] bw_period_mask(input logic [1:0] code);
      case (code)
         BW2:     return 3'b001;
         BW4:     return 3'b011;
         BW8:     return 3'b111;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [2:0] bw_need(input logic [2:0] code);
      case (code)
         BU1:     return 3'd1;
         BU2:     return 3'd2;
         BU4:     return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [7:0] steer_byte(input logic [1:0]  bsl,
                                             input logic [31:0] word,
                                             input logic [1:0]  lane);
      logic [31:0] shifted;
      shifted = word >> {lane, 3'b000};
      case (bsl)
         BSL_LO:   return word[7:0];
         BSL_HI:   return word[15:8];
         BSL_WORD: return shifted[7:0];
         BSL_ALT:  return shifted[7:0];
         default:  return shifted[7:0];
      endcase
   endfunction

endpackage

// File: rtl/video_fetch_bw_slot.sv
// Bandwidth slot counter: walks DRAM cycles through the descriptor period and
// raises a registered request for the first `need` slots of each period.
module video_bw_slot
   import video_fetch_pkg::*;
(
   input  logic       clk,
   input  logic       res,
   input  logic       c3,
   input  logic       line_start_s,
   input  logic       video_go,
   input  logic [4:0] video_bw,
   output logic       video_req
);

   logic [2:0] slot_r;
   logic [2:0] slot_next_s;
   logic [2:0] mask_s;
   logic [2:0] need_s;
   logic       req_r;

   // Next slot: line start outranks the DRAM-cycle advance.
   always_comb begin
      mask_s      = bw_period_mask(video_bw[4:3]);
      need_s      = bw_need(video_bw[2:0]);
      slot_next_s = slot_r;
      if (line_start_s) begin
         slot_next_s = 3'd0;
      end else if (c3 && video_go) begin
         slot_next_s = (slot_r + 3'd1) & mask_s;
      end else begin
         slot_next_s = slot_r;
      end
   end

   // Slot and request registers; the request tracks the slot just entered.
   always_ff @(posedge clk) begin
      if (res) begin
         slot_r <= 3'd0;
         req_r  <= 1'b0;
      end else begin
         slot_r <= slot_next_s;
         req_r  <= video_go && (slot_next_s < need_s);
      end
   end

   assign video_req = req_r;

endmodule

// File: rtl/video_fetch.sv
// Video DRAM fetch stage: slot requests, two-word return buffer, byte-steered
// fetch register for the renderer and text char-code latch.
module video_fetch
   import video_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        res,
   input  logic        c3,
   input  logic        line_start_s,
   input  logic        video_go,
   input  logic [4:0]  video_bw,
   output logic        video_req,
   input  logic        dram_strobe,
   input  logic [15:0] dram_rdata,
   input  logic        char_phase,
   input  logic        fetch_stb,
   input  logic [3:0]  fetch_sel,
   input  logic [1:0]  fetch_bsl,
   output logic [31:0] fetch_data,
   output logic [15:0] txt_char
);

   logic [15:0] tmp0_r;
   logic [15:0] tmp1_r;
   logic        wp_r;
   logic        wr_idx_s;
   logic        wp_next_s;
   logic [31:0] fetch_r;
   logic [31:0] fetch_next_s;
   logic [15:0] txt_r;

   video_bw_slot u_bw_slot (
      .clk          (clk),
      .res          (res),
      .c3           (c3),
      .line_start_s (line_start_s),
      .video_go     (video_go),
      .video_bw     (video_bw),
      .video_req    (video_req)
   );

   // A fetch rewinds the buffer, so a coincident word lands in slot 0.
   always_comb begin
      wr_idx_s     = wp_r;
      wp_next_s    = wp_r;
      fetch_next_s = fetch_r;
      if (fetch_stb) begin
         wr_idx_s = 1'b0;
      end else begin
         wr_idx_s = wp_r;
      end
      if (dram_strobe) begin
         wp_next_s = ~wr_idx_s;
      end else if (fetch_stb) begin
         wp_next_s = 1'b0;
      end else begin
         wp_next_s = wp_r;
      end
      for (int i = 0; i < 4; i++) begin
         if (fetch_stb && fetch_sel[i]) begin
            fetch_next_s[8*i +: 8] = steer_byte(fetch_bsl, {tmp1_r, tmp0_r}, 2'(i));
         end else begin
            fetch_next_s[8*i +: 8] = fetch_r[8*i +: 8];
         end
      end
   end

   // Return buffer, fetch register and char-code latch.
   always_ff @(posedge clk) begin
      if (res) begin
         tmp0_r  <= 16'h0000;
         tmp1_r  <= 16'h0000;
         wp_r    <= 1'b0;
         fetch_r <= 32'h0000_0000;
         txt_r   <= 16'h0000;
      end else begin
         wp_r    <= wp_next_s;
         fetch_r <= fetch_next_s;
         if (dram_strobe && !wr_idx_s) begin
            tmp0_r <= dram_rdata;
         end
         if (dram_strobe && wr_idx_s) begin
            tmp1_r <= dram_rdata;
         end
         if (dram_strobe && char_phase) begin
            txt_r <= dram_rdata;
         end
      end
   end

   assign fetch_data = fetch_r;
   assign txt_char   = txt_r;

endmodule
